// File: rtl/padd_pkg.sv
// Shared constants and slicing helpers for the pipelined adder.
// A chunk is one pipeline stage's slice of the operands: CW = WIDTH / STAGES bits.
package padd_pkg;

  // Default geometry: a 32-bit add split over four register stages.
  localparam int PADD_DEF_WIDTH  = 32;
  localparam int PADD_DEF_STAGES = 4;

  // Bits handled by each stage.
  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

  // Index of the least-significant bit of chunk k.
  function automatic int chunk_slice(input int k, input int cw);
    return k * cw;
  endfunction

endpackage

// File: rtl/fullAdder.sv
// One-bit full adder cell. This is the ripple building block reused from the
// original 8-bit adder, with its port order kept: (sum, cout, a, b, cin).
module fullAdder (
  output logic sum,
  output logic cout,
  input  logic a,
  input  logic b,
  input  logic cin
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/padd_chunk.sv
// CW-bit combinational ripple-carry chunk built from fullAdder cells.
// c_msb_in is the carry entering the top bit, which the final stage needs to
// form the signed-overflow flag.
module padd_chunk #(
  parameter int CW = 8
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          ci,
  output logic [CW-1:0] s,
  output logic          co,
  output logic          c_msb_in
);

  // Each bit has its own carry wires, so the chain is a series of distinct
  // nets rather than one vector that feeds back into itself.
  for (genvar i = 0; i < CW; i++) begin : g_bit
    logic w_ci;
    logic w_co;

    if (i == 0) begin : g_first
      assign w_ci = ci;
    end else begin : g_next
      assign w_ci = g_bit[i-1].w_co;
    end

    fullAdder u_fa (
      .sum  (s[i]),
      .cout (w_co),
      .a    (a[i]),
      .b    (b[i]),
      .cin  (w_ci)
    );
  end

  assign co       = g_bit[CW-1].w_co;
  assign c_msb_in = g_bit[CW-1].w_ci;

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit adder split into STAGES ripple chunks with a register stage after
// each chunk and a valid/ready handshake on both sides. Latency is STAGES
// cycles. When the pipe is not stalled it accepts one add per cycle.
// Optional feature: define PADD_OVF_EN to add the registered signed-overflow
// output ovf. Without it, the port and its flop are absent.
module pipelined_adder
  import padd_pkg::*;
#(
  parameter int WIDTH  = PADD_DEF_WIDTH,
  parameter int STAGES = PADD_DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = chunk_width(WIDTH, STAGES);

  if ((STAGES < 1) || (STAGES > WIDTH)) begin : g_bad_stages
    $error("pipelined_adder: STAGES=%0d must be in 1..WIDTH=%0d", STAGES, WIDTH);
  end
  if ((WIDTH % STAGES) != 0) begin : g_bad_split
    $error("pipelined_adder: WIDTH=%0d is not a multiple of STAGES=%0d", WIDTH, STAGES);
  end

  // Stage record. psum has bits [(k+1)*CW-1:0] filled in by stage k, and bits
  // above that are still zero. The op_* fields carry the untouched operand bits
  // forward to the stages that have not consumed them yet.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] psum;
    logic             carry;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
  } stage_t;

  stage_t            r_stg        [STAGES];
  stage_t            w_in         [STAGES];
  stage_t            w_nxt        [STAGES];
  logic [CW-1:0]     w_chunk_s    [STAGES];
  logic              w_chunk_co   [STAGES];
  logic              w_chunk_cmsb [STAGES];
  logic [STAGES-1:0] w_vld;
  logic [STAGES-1:0] w_rdy;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = chunk_slice(k, CW);
    // Bits below k set: OR-ing them in makes the AND reduction cover
    // stages k..STAGES-1 only.
    localparam logic [STAGES-1:0] LOW_MASK = {STAGES{1'b1}} >> (STAGES - k);

    if (k == 0) begin : g_head
      assign w_in[k] = '{valid: in_valid, psum: '0, carry: cin, op_a: a, op_b: b};
    end else begin : g_link
      assign w_in[k] = r_stg[k-1];
    end

    padd_chunk #(.CW(CW)) u_chunk (
      .a        (w_in[k].op_a[LO +: CW]),
      .b        (w_in[k].op_b[LO +: CW]),
      .ci       (w_in[k].carry),
      .s        (w_chunk_s[k]),
      .co       (w_chunk_co[k]),
      .c_msb_in (w_chunk_cmsb[k])
    );

    assign w_nxt[k] = '{valid: w_in[k].valid,
                        psum:  w_in[k].psum | (WIDTH'(w_chunk_s[k]) << LO),
                        carry: w_chunk_co[k],
                        op_a:  w_in[k].op_a,
                        op_b:  w_in[k].op_b};

    assign w_vld[k] = r_stg[k].valid;

    // Stage k can load if any stage from k to the output holds a bubble, or if
    // the output is draining. This is the unrolled form of
    // rdy[k] = ~v[k] | rdy[k+1], written so no net depends on itself.
    // in_valid never reaches this path.
    assign w_rdy[k] = out_ready | ~&(w_vld | LOW_MASK);
  end

  // Advance every stage that is ready. Data fields load only with a real beat,
  // so a stalled or drained output keeps showing its last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the data fields are cleared as well as the valid bits, because
      // sum and cout must read back zero after reset, not leftover data.
      for (int k = 0; k < STAGES; k++) begin
        r_stg[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_rdy[k]) begin
          // NOTE: non-blocking assignments let every stage sample its
          // upstream neighbour's pre-edge value, so beats shift by exactly
          // one stage per clock whatever the loop order.
          if (w_in[k].valid) begin
            r_stg[k] <= w_nxt[k];
          end else begin
            r_stg[k].valid <= 1'b0;
          end
        end
      end
    end
  end

  assign in_ready  = w_rdy[0];
  assign out_valid = r_stg[STAGES-1].valid;
  assign sum       = r_stg[STAGES-1].psum;
  assign cout      = r_stg[STAGES-1].carry;

`ifdef PADD_OVF_EN
  logic r_ovf;

  // Signed overflow is registered with the final stage and follows the same
  // load and hold rules as sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_rdy[STAGES-1] && w_in[STAGES-1].valid) begin
      r_ovf <= w_chunk_cmsb[STAGES-1] ^ w_chunk_co[STAGES-1];
    end
  end

  assign ovf = r_ovf;
`else
  logic w_unused_cmsb;
  assign w_unused_cmsb = w_chunk_cmsb[STAGES-1];
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder. Three configurations are instantiated:
// 32/4 (main), 8/1 and 8/8. Expected {ovf, cout, sum} values are pushed when a
// beat is accepted and compared when that beat leaves the DUT.
// Build with PADD_OVF_EN defined to also check the ovf output.
module tb_pipelined_adder;

`ifdef PADD_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  int n_checks  = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int n_acc     = 0;
  int n_pop     = 0;
  int first_pop = 0;
  int last_pop  = 0;
  int n_acc1    = 0;
  int n_pop1    = 0;
  int n_acc8    = 0;
  int n_pop8    = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, cin, cout, w_ovf;
  logic [31:0] a, b, sum;

  logic       s_valid, s_ordy, s_cin;
  logic [7:0] s_a, s_b;
  logic       s1_in_ready, s1_out_valid, s1_cout, w_ovf1;
  logic       s8_in_ready, s8_out_valid, s8_cout, w_ovf8;
  logic [7:0] s1_sum, s8_sum;

  logic        obs_valid, acc;
  logic [33:0] obs_res;
  logic [33:0] q_exp [$];
  logic [9:0]  q1 [$];
  logic [9:0]  q8 [$];

  pipelined_adder #(.WIDTH(32), .STAGES(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
`ifdef PADD_OVF_EN
    , .ovf(w_ovf)
`endif
  );

  pipelined_adder #(.WIDTH(8), .STAGES(1)) u_dut_s1 (
    .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(s1_in_ready),
    .a(s_a), .b(s_b), .cin(s_cin), .out_valid(s1_out_valid), .out_ready(s_ordy),
    .sum(s1_sum), .cout(s1_cout)
`ifdef PADD_OVF_EN
    , .ovf(w_ovf1)
`endif
  );

  pipelined_adder #(.WIDTH(8), .STAGES(8)) u_dut_s8 (
    .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(s8_in_ready),
    .a(s_a), .b(s_b), .cin(s_cin), .out_valid(s8_out_valid), .out_ready(s_ordy),
    .sum(s8_sum), .cout(s8_cout)
`ifdef PADD_OVF_EN
    , .ovf(w_ovf8)
`endif
  );

`ifndef PADD_OVF_EN
  assign w_ovf  = 1'b0;
  assign w_ovf1 = 1'b0;
  assign w_ovf8 = 1'b0;
`endif

  function automatic logic [33:0] model32(input logic [31:0] ia, input logic [31:0] ib,
                                          input logic ic);
    logic [32:0] s;
    logic        v;
    s = {1'b0, ia} + {1'b0, ib} + {32'd0, ic};
    v = (ia[31] == ib[31]) && (s[31] != ia[31]);
    return {v & OVF_EN, s};
  endfunction

  function automatic logic [9:0] model8(input logic [7:0] ia, input logic [7:0] ib,
                                        input logic ic);
    logic [8:0] s;
    logic       v;
    s = {1'b0, ia} + {1'b0, ib} + {8'd0, ic};
    v = (ia[7] == ib[7]) && (s[7] != ia[7]);
    return {v & OVF_EN, s};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of stimulus to the 32/4 DUT, log the handshakes that will
  // complete at the next posedge, and return at the following negedge.
  task automatic drive(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                       input logic ic, input logic ordy);
    in_valid = iv; a = ia; b = ib; cin = ic; out_ready = ordy;
    #1;
    acc       = in_valid && in_ready;
    obs_valid = out_valid;
    obs_res   = {w_ovf, cout, sum};
    if (acc) begin
      q_exp.push_back(model32(ia, ib, ic));
      n_acc++;
    end
    if (out_valid && out_ready) begin
      n_pop++;
      if (n_pop == 1) first_pop = cyc;
      last_pop = cyc;
      check("sb_queue_empty", 64'(q_exp.size() == 0), 64'd0);
      if (q_exp.size() != 0) check("sb_result", obs_res, q_exp.pop_front());
    end
    cyc++;
    @(negedge clk);
  endtask

  // One cycle of shared stimulus for the two 8-bit DUTs, each with its own queue.
  task automatic drive8(input logic iv, input logic [7:0] ia, input logic [7:0] ib,
                        input logic ic, input logic ordy);
    s_valid = iv; s_a = ia; s_b = ib; s_cin = ic; s_ordy = ordy;
    #1;
    if (iv && s1_in_ready) begin q1.push_back(model8(ia, ib, ic)); n_acc1++; end
    if (iv && s8_in_ready) begin q8.push_back(model8(ia, ib, ic)); n_acc8++; end
    if (s1_out_valid && ordy) begin
      n_pop1++;
      check("sb1_queue_empty", 64'(q1.size() == 0), 64'd0);
      if (q1.size() != 0) check("sb1_result", {w_ovf1, s1_cout, s1_sum}, q1.pop_front());
    end
    if (s8_out_valid && ordy) begin
      n_pop8++;
      check("sb8_queue_empty", 64'(q8.size() == 0), 64'd0);
      if (q8.size() != 0) check("sb8_result", {w_ovf8, s8_cout, s8_sum}, q8.pop_front());
    end
    @(negedge clk);
  endtask

  // Send a single beat into an idle pipe and wait a bounded time for the
  // result. lat stays 0 if the result never appears.
  task automatic single(input logic [31:0] ia, input logic [31:0] ib, input logic ic,
                        output int lat);
    lat = 0;
    drive(1'b1, ia, ib, ic, 1'b1);
    check("single_accept", 64'(acc), 64'd1);
    for (int i = 1; i <= 20; i++) begin
      drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
      if (obs_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && q_exp.size() > 0; i++) drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [33:0] hold_res;
    logic [31:0] ca, cb;
    logic        cc;
    logic [7:0]  da [3];
    logic [7:0]  db [3];
    logic        dc [3];

    da = '{8'hFF, 8'h00, 8'hFF};
    db = '{8'h01, 8'h00, 8'hFF};
    dc = '{1'b0, 1'b1, 1'b1};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    s_valid = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0; s_ordy = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_ovf", 64'(w_ovf), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_small_valid", 64'({s1_out_valid, s8_out_valid}), 64'd0);
    @(negedge clk);

    // All-ones plus one wraps to zero with carry out, after exactly 4 cycles.
    single(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat);
    check("t1_latency", 64'(lat), 64'd4);
    check("t1_sum", 64'(obs_res[31:0]), 64'd0);
    check("t1_cout", 64'(obs_res[32]), 64'd1);
    // cin alone: 0 + 0 + 1.
    single(32'd0, 32'd0, 1'b1, lat);
    check("cin_sum", 64'(obs_res[31:0]), 64'd1);
    check("cin_cout", 64'(obs_res[32]), 64'd0);

    // 16 back-to-back random beats must come out on 16 consecutive cycles.
    n_acc = 0; n_pop = 0;
    for (int i = 0; i < 16; i++) drive(1'b1, $urandom, $urandom, 1'($urandom), 1'b1);
    drain(20);
    check("t2_accepted", 64'(n_acc), 64'd16);
    check("t2_popped", 64'(n_pop), 64'd16);
    check("t2_window", 64'(last_pop - first_pop), 64'd15);
    check("t2_leftover", 64'(q_exp.size()), 64'd0);

    // Stall the output for 10 cycles while offering beats: the pipe fills,
    // then the output holds steady.
    n_acc = 0; n_pop = 0; hold_res = '0;
    ca = $urandom; cb = $urandom; cc = 1'($urandom);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, ca, cb, cc, 1'b0);
      if (acc) begin
        ca = $urandom; cb = $urandom; cc = 1'($urandom);
      end
      if (i == 5) hold_res = {w_ovf, cout, sum};
    end
    check("t3_accepted", 64'(n_acc), 64'd4);
    check("t3_in_ready", 64'(in_ready), 64'd0);
    check("t3_out_valid", 64'(out_valid), 64'd1);
    check("t3_hold", {w_ovf, cout, sum}, hold_res);
    drain(20);
    check("t3_drained", 64'(n_pop), 64'd4);
    check("t3_leftover", 64'(q_exp.size()), 64'd0);

    // Alternating input valid with a toggling output ready.
    n_acc = 0; n_pop = 0;
    for (int i = 0; i < 24; i++) drive(1'(i % 2 == 0), $urandom, $urandom, 1'($urandom), 1'(i % 3 != 2));
    drain(30);
    check("t4_leftover", 64'(q_exp.size()), 64'd0);
    check("t4_in_eq_out", 64'(n_pop), 64'(n_acc));

    // Reset with three beats in flight: none of them may ever appear.
    n_acc = 0;
    for (int i = 0; i < 3; i++) drive(1'b1, $urandom | 32'h1, $urandom, 1'b1, 1'b1);
    check("t5_accepted", 64'(n_acc), 64'd3);
    in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q_exp.delete();
    #1;
    check("t5_out_valid", 64'(out_valid), 64'd0);
    check("t5_sum", 64'(sum), 64'd0);
    check("t5_cout", 64'(cout), 64'd0);
    n_pop = 0;
    for (int i = 0; i < 8; i++) drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    check("t5_no_stale", 64'(n_pop), 64'd0);

`ifdef PADD_OVF_EN
    single(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, lat);
    check("t6a_ovf", 64'(obs_res[33]), 64'd1);
    check("t6a_cout", 64'(obs_res[32]), 64'd0);
    single(32'h8000_0000, 32'h8000_0000, 1'b0, lat);
    check("t6b_ovf", 64'(obs_res[33]), 64'd1);
    check("t6b_cout", 64'(obs_res[32]), 64'd1);
    check("t6b_sum", 64'(obs_res[31:0]), 64'd0);
`endif

    // 8/1 and 8/8: carry-wrap edge cases first, then random valid/ready traffic.
    for (int i = 0; i < 48; i++) begin
      if (i < 3) drive8(1'b1, da[i], db[i], dc[i], 1'b1);
      else drive8(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
                  1'($urandom), 1'($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 40 && (q1.size() > 0 || q8.size() > 0); i++)
      drive8(1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
    check("s1_leftover", 64'(q1.size()), 64'd0);
    check("s8_leftover", 64'(q8.size()), 64'd0);
    check("s1_in_eq_out", 64'(n_pop1), 64'(n_acc1));
    check("s8_in_eq_out", 64'(n_pop8), 64'(n_acc8));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
